// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, total-length helpers and TinyVGA PMOD bit positions.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   // uo_vga byte layout: {hsync,B0,G0,R0,vsync,B1,G1,R1}
   localparam int HSYNC_BIT = 7;
   localparam int VSYNC_BIT = 3;
   localparam int R1_BIT    = 0;
   localparam int G1_BIT    = 1;
   localparam int B1_BIT    = 2;
   localparam int R0_BIT    = 4;
   localparam int G0_BIT    = 5;
   localparam int B0_BIT    = 6;

   typedef struct packed {
      logic active;
      logic hs_n;
      logic vs_n;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

   function automatic int h_total(input int act, input int fp, input int sw, input int bp);
      return act + fp + sw + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sw, input int bp);
      return act + fp + sw + bp;
   endfunction

endpackage

// File: rtl/sig_delay.sv
// Enabled shift register with async reset; DEPTH=0 degenerates to a wire.
module sig_delay #(
   parameter int                WIDTH     = 1,
   parameter int                DEPTH     = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign q = d;
      end else begin : g_pipe
         logic [DEPTH-1:0][WIDTH-1:0] pipe;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
            end else if (ena) begin
               pipe[0] <= d;
               for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign q = pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// VGA raster counters plus sync/blank alignment to the pixel pipeline and
// TinyVGA PMOD output packing.
module vga_timing_out
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF,
   parameter int PIPE_DELAY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       line_end,
   output logic       frame_end,
   input  logic [5:0] rgb_in,
   output logic [7:0] uo_vga
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [7:0] UO_IDLE = 8'h88;

   // Assert asynchronously, release on a clock edge so no state leaves reset mid-cycle.
   logic [1:0] rst_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_q <= 2'b00;
      else        rst_q <= {rst_q[0], 1'b1};
   end

   assign rst_int_n = rst_q[1];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         x <= '0;
         y <= '0;
      end else if (ena) begin
         if (x == H_LAST) begin
            x <= '0;
            y <= (y == V_LAST) ? '0 : y + 10'd1;
         end else begin
            x <= x + 10'd1;
         end
      end
   end

   assign active    = (x < H_ACT) && (y < V_ACT);
   assign line_end  = ena && (x == H_LAST);
   assign frame_end = line_end && (y == V_LAST);

   sync_t raw, dly;

   always_comb begin
      raw        = SYNC_IDLE;
      raw.active = active;
      raw.hs_n   = !((x >= HS_BEG) && (x < HS_END));
      raw.vs_n   = !((y >= VS_BEG) && (y < VS_END));
   end

   sig_delay #(
      .WIDTH     (3),
      .DEPTH     (PIPE_DELAY),
      .RESET_VAL (SYNC_IDLE)
   ) u_dly (
      .clk   (clk),
      .rst_n (rst_int_n),
      .ena   (ena),
      .d     (raw),
      .q     (dly)
   );

   // Colour is forced to zero outside the delayed display window.
   logic [7:0] uo_nxt;

   always_comb begin
      uo_nxt            = '0;
      uo_nxt[HSYNC_BIT] = dly.hs_n;
      uo_nxt[VSYNC_BIT] = dly.vs_n;
      if (dly.active) begin
         uo_nxt[R1_BIT] = rgb_in[5];
         uo_nxt[R0_BIT] = rgb_in[4];
         uo_nxt[G1_BIT] = rgb_in[3];
         uo_nxt[G0_BIT] = rgb_in[2];
         uo_nxt[B1_BIT] = rgb_in[1];
         uo_nxt[B0_BIT] = rgb_in[0];
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) uo_vga <= UO_IDLE;
      else if (ena)   uo_vga <= uo_nxt;
   end

endmodule
